// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode receiver: FSM states,
// special scancodes and frame geometry.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam int         FRAME_BITS = 11;
  localparam int         DATA_BITS  = FRAME_BITS - 3;

  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Dual-bit 2-flop synchronizer for the raw PS/2 clock and data lines, plus
// falling-edge detection on the synchronized clock.
module ps2_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic ps2_clock_i,
  input  logic ps2_data_i,
  output logic data_o,
  output logic fall_o
);

  logic [1:0] meta_q, meta_d;
  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;

  always_comb begin
    meta_d = {ps2_data_i, ps2_clock_i};
    sync_d = meta_q;
    prev_d = sync_q[0];
  end

  // Idle PS/2 lines float high, so reset to 1 to avoid a false edge on release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= 2'b11;
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign data_o = sync_q[1];
  assign fall_o = prev_q & ~sync_q[0];

endmodule

// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard frame receiver and make/break decoder. Define PS2_TIMEOUT_EN
// to abort partial frames after TIMEOUT_CYCLES clocks without a ps2_clock edge.
module ps2_scancode_receiver
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic [7:0] data_PS2key,
  output logic       ctrl_PS2pressed,
  output logic       scan_valid,
  output logic       frame_err
);

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be positive");
  end

  logic ps2_data_s;
  logic ps2_fall;

  ps2_sync_edge u_sync_edge (
    .clock       (clock),
    .reset       (reset),
    .ps2_clock_i (ps2_clock),
    .ps2_data_i  (ps2_data),
    .data_o      (ps2_data_s),
    .fall_o      (ps2_fall)
  );

  ps2_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       parity_q, parity_d;
  logic       break_q, break_d;
  logic [7:0] key_q, key_d;
  logic       pressed_q, pressed_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;

`ifdef PS2_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  always_comb begin
    // NOTE: every _d takes its hold value first, so no path can infer a latch.
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    break_d   = break_q;
    key_d     = key_q;
    pressed_d = pressed_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    if (ps2_fall) begin
      case (state_q)
        ST_IDLE: begin
          if (!ps2_data_s) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d   = {ps2_data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          parity_d = ps2_data_s;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (ps2_data_s && odd_parity_ok(shift_q, parity_q)) begin
            valid_d = 1'b1;
            // E0 prefixes are dropped: neither key nor break state moves.
            if (shift_q == CODE_BREAK) begin
              break_d = 1'b1;
            end else if (shift_q != CODE_EXT) begin
              if (break_q) begin
                break_d = 1'b0;
                if (shift_q == key_q) pressed_d = 1'b0;
              end else begin
                key_d     = shift_q;
                pressed_d = 1'b1;
              end
            end
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

`ifdef PS2_TIMEOUT_EN
    to_cnt_d = to_cnt_q + TO_W'(1);
    if (state_q == ST_IDLE || ps2_fall) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
      to_cnt_d = '0;
      state_d  = ST_IDLE;
      err_d    = 1'b1;
    end
`endif
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      break_q   <= 1'b0;
      key_q     <= '0;
      pressed_q <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef PS2_TIMEOUT_EN
      to_cnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      break_q   <= break_d;
      key_q     <= key_d;
      pressed_q <= pressed_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
`ifdef PS2_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
`endif
    end
  end

  assign data_PS2key     = key_q;
  assign ctrl_PS2pressed = pressed_q;
  assign scan_valid      = valid_q;
  assign frame_err       = err_q;

endmodule
